hamming_mem_engine: RTL and testbench

HAMMING_MEM_ENGINE -- requirements
Module: hamming_mem_engine

---
 rtl/hamming_pkg.sv | 41 ++++
 rtl/hamming_secded.sv | 49 ++++
 rtl/hamming_mem_engine.sv | 165 ++++++++++++++++
 tb/tb_hamming_mem_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types and codeword layout for the Hamming SECDED memory engine
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAP_HI,
    ST_CALC,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_e;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Flag bit positions inside the decoded result's high byte
  localparam int FLAG_DBL = 7;
  localparam int FLAG_SGL = 6;

  localparam int POS_P0 = 0;
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_P4 = 4;
  localparam int POS_P8 = 8;
  localparam int POS_D1 = 3;

  // Codeword positions covered by each Hamming parity bit (bit 0 excluded)
  localparam logic [15:0] MASK_P1 = 16'hAAAA;
  localparam logic [15:0] MASK_P2 = 16'hCCCC;
  localparam logic [15:0] MASK_P4 = 16'hF0F0;
  localparam logic [15:0] MASK_P8 = 16'hFF00;

  function automatic logic [10:0] code_data(input logic [15:0] c);
    return {c[15:9], c[7:5], c[POS_D1]};
  endfunction

endpackage

// File: rtl/hamming_secded.sv
// rtl/hamming_secded.sv - combinational (16,11) SECDED encoder and decoder
module hamming_secded
  import hamming_pkg::*;
(
  input  logic [10:0] data_i,
  output logic [15:0] code_o,
  input  logic [15:0] code_i,
  output logic [10:0] data_o,
  output logic        single_o,
  output logic        double_o
);

  logic [15:0] raw;
  logic [15:0] fixed;
  logic [3:0]  syn;
  logic        par;

  always_comb begin
    raw            = {data_i[10:4], 1'b0, data_i[3:1], 1'b0, data_i[0], 3'b000};
    code_o         = raw;
    code_o[POS_P1] = ^(raw & MASK_P1);
    code_o[POS_P2] = ^(raw & MASK_P2);
    code_o[POS_P4] = ^(raw & MASK_P4);
    code_o[POS_P8] = ^(raw & MASK_P8);
    code_o[POS_P0] = ^code_o[15:1];
  end

  // Syndrome is the parity of each group including its received check bit
  always_comb begin
    syn      = {^(code_i & MASK_P8), ^(code_i & MASK_P4),
                ^(code_i & MASK_P2), ^(code_i & MASK_P1)};
    par      = ^code_i;
    fixed    = code_i;
    single_o = 1'b0;
    double_o = 1'b0;
    if (syn != 4'd0) begin
      if (par) begin
        fixed[syn] = ~code_i[syn];
        single_o   = 1'b1;
      end else begin
        double_o   = 1'b1;
      end
    end else if (par) begin
      single_o = 1'b1;
    end
    data_o = code_data(fixed);
  end

endmodule

// File: rtl/hamming_mem_engine.sv
// rtl/hamming_mem_engine.sv - byte-wide memory walker that SECDED-encodes or corrects a block of words
module hamming_mem_engine
  import hamming_pkg::*;
#(
  parameter int         NWORDS   = 15,
  parameter logic [7:0] SRC_BASE = 8'd0,
  parameter logic [7:0] DST_BASE = 8'd30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       mode,
  output logic       ack,
  output logic [7:0] MemAdr,
  output logic [7:0] DatIn,
  input  logic [7:0] DatOut,
  output logic       ReadEn,
  output logic       WriteEn,
  output logic [7:0] sec_ct,
  output logic [7:0] ded_ct
);

  localparam logic [6:0] LAST_IDX = (NWORDS > 0) ? 7'(NWORDS - 1) : 7'd0;

  state_e      state_q;
  mode_e       mode_q;
  logic [6:0]  idx_q;
  logic [6:0]  idx_d;
  logic [7:0]  lo_q;
  logic [15:0] code_q;
  logic [7:0]  res_hi_q;
  logic        ack_q;
  logic [7:0]  adr_q;
  logic [7:0]  dat_q;
  logic        rd_q;
  logic        wr_q;
  logic [7:0]  sec_q;
  logic [7:0]  ded_q;

  logic [15:0] enc_code;
  logic [10:0] dec_data;
  logic        dec_single;
  logic        dec_double;
  logic [15:0] result_d;

  function automatic logic [7:0] word_adr(input logic [7:0] base, input logic [6:0] idx,
                                          input logic hi);
    return base + {idx, hi};
  endfunction

  hamming_secded u_secded (
    .data_i   (code_q[10:0]),
    .code_o   (enc_code),
    .code_i   (code_q),
    .data_o   (dec_data),
    .single_o (dec_single),
    .double_o (dec_double)
  );

  assign idx_d = idx_q + 7'd1;

  always_comb begin
    result_d = enc_code;
    if (mode_q == MODE_DEC) begin
      result_d                = '0;
      result_d[10:0]          = dec_data;
      result_d[8 + FLAG_DBL]  = dec_double;
      result_d[8 + FLAG_SGL]  = dec_single;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ENC;
      idx_q    <= '0;
      lo_q     <= '0;
      code_q   <= '0;
      res_hi_q <= '0;
      ack_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      sec_q    <= '0;
      ded_q    <= '0;
    end else if (req) begin
      // A high req always parks the engine; bytes already written stay written
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_q <= mode_e'(mode);
          sec_q  <= '0;
          ded_q  <= '0;
          idx_q  <= '0;
          if (NWORDS == 0) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RD_LO;
            adr_q   <= word_adr(SRC_BASE, 7'd0, 1'b0);
            rd_q    <= 1'b1;
          end
        end
        ST_RD_LO: begin
          state_q <= ST_RD_HI;
          adr_q   <= word_adr(SRC_BASE, idx_q, 1'b1);
        end
        ST_RD_HI: begin
          state_q <= ST_CAP_HI;
          lo_q    <= DatOut;
          rd_q    <= 1'b0;
        end
        ST_CAP_HI: begin
          state_q <= ST_CALC;
          code_q  <= {DatOut, lo_q};
        end
        ST_CALC: begin
          state_q  <= ST_WR_LO;
          res_hi_q <= result_d[15:8];
          adr_q    <= word_adr(DST_BASE, idx_q, 1'b0);
          dat_q    <= result_d[7:0];
          wr_q     <= 1'b1;
          if (mode_q == MODE_DEC) begin
            if (dec_single && sec_q != 8'hFF) sec_q <= sec_q + 8'd1;
            if (dec_double && ded_q != 8'hFF) ded_q <= ded_q + 8'd1;
          end
        end
        ST_WR_LO: begin
          state_q <= ST_WR_HI;
          adr_q   <= word_adr(DST_BASE, idx_q, 1'b1);
          dat_q   <= res_hi_q;
        end
        ST_WR_HI: begin
          wr_q <= 1'b0;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RD_LO;
            idx_q   <= idx_d;
            adr_q   <= word_adr(SRC_BASE, idx_d, 1'b0);
            rd_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          // ack lags DONE entry by one edge so it lands at 6*NWORDS+1
          ack_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign MemAdr  = adr_q;
  assign DatIn   = dat_q;
  assign ReadEn  = rd_q;
  assign WriteEn = wr_q;
  assign sec_ct  = sec_q;
  assign ded_ct  = ded_q;

endmodule

// File: tb/tb_hamming_mem_engine.sv
// tb/tb_hamming_mem_engine.sv - scoreboard bench for hamming_mem_engine against a behavioural SECDED model
module tb_hamming_mem_engine;

  localparam int         NW  = 15;
  localparam logic [7:0] SRC = 8'd0;
  localparam logic [7:0] DST = 8'd30;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       mode;
  logic       ack;
  logic [7:0] MemAdr;
  logic [7:0] DatIn;
  logic [7:0] DatOut;
  logic       ReadEn;
  logic       WriteEn;
  logic [7:0] sec_ct;
  logic [7:0] ded_ct;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] adr;
    logic [7:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  mem[256];
  logic [15:0] src_words[NW];
  int          exp_sec;
  int          exp_ded;

  always #5 clk = ~clk;

  hamming_mem_engine dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .mode    (mode),
    .ack     (ack),
    .MemAdr  (MemAdr),
    .DatIn   (DatIn),
    .DatOut  (DatOut),
    .ReadEn  (ReadEn),
    .WriteEn (WriteEn),
    .sec_ct  (sec_ct),
    .ded_ct  (ded_ct)
  );

  always @(posedge clk) begin
    if (WriteEn) mem[MemAdr] <= DatIn;
    if (ReadEn) DatOut <= mem[MemAdr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] c;
    int k;
    logic p;
    c = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int pw = 1; pw < 16; pw = pw * 2) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++) if ((pos & pw) != 0) p = p ^ c[pos];
      c[pw] = p;
    end
    p = 1'b0;
    for (int pos = 1; pos < 16; pos++) p = p ^ c[pos];
    c[0] = p;
    return c;
  endfunction

  function automatic logic [17:0] ref_decode(input logic [15:0] cw);
    logic [15:0] c;
    logic [10:0] d;
    int syn;
    int ones;
    int k;
    logic sgl;
    logic dbl;
    c    = cw;
    syn  = 0;
    ones = 0;
    for (int pos = 0; pos < 16; pos++) begin
      if (c[pos]) begin
        ones++;
        if (pos != 0) syn = syn ^ pos;
      end
    end
    sgl = 1'b0;
    dbl = 1'b0;
    if (syn != 0 && (ones % 2) == 1) begin
      c[syn] = ~c[syn];
      sgl = 1'b1;
    end else if (syn == 0 && (ones % 2) == 1) begin
      sgl = 1'b1;
    end else if (syn != 0) begin
      dbl = 1'b1;
    end
    k = 0;
    d = '0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos];
        k++;
      end
    end
    return {sgl, dbl, dbl, sgl, 3'b000, d};
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (WriteEn) begin
      chk("rd_wr_exclusive", {31'd0, ReadEn}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_adr", {24'd0, MemAdr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_adr", {24'd0, MemAdr}, {24'd0, e.adr});
        chk("write_dat", {24'd0, DatIn}, {24'd0, e.dat});
      end
    end
  end

  task automatic load_and_predict(input bit m, input int nwords_written);
    logic [17:0] r;
    logic [15:0] res;
    wr_t e;
    exp_sec = 0;
    exp_ded = 0;
    for (int w = 0; w < NW; w++) begin
      mem[8'(SRC + 2 * w)]     <= src_words[w][7:0];
      mem[8'(SRC + 2 * w + 1)] <= src_words[w][15:8];
      if (m) begin
        r   = ref_decode(src_words[w]);
        res = r[15:0];
        if (r[17] && exp_sec < 255) exp_sec++;
        if (r[16] && exp_ded < 255) exp_ded++;
      end else begin
        res = ref_encode(src_words[w][10:0]);
      end
      if (w < nwords_written) begin
        e.adr = 8'(DST + 2 * w);
        e.dat = res[7:0];
        exp_q.push_back(e);
        e.adr = 8'(DST + 2 * w + 1);
        e.dat = res[15:8];
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  // stop_at: 0 = full run, otherwise edge at which req (abort) or reset is applied
  task automatic do_run(input bit m, input int stop_at, input bit use_reset);
    int nwr;
    int rise;
    nwr = NW;
    if (stop_at > 0) begin
      nwr = 0;
      for (int w = 0; w < NW; w++) if (6 * w + 6 < stop_at) nwr++;
    end
    load_and_predict(m, nwr);
    mode = m;
    req  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mode = ~m;
    rise = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k == stop_at) begin
        if (use_reset) reset = 1'b1;
        else req = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (k == stop_at) begin
        chk("stop_writeen", {31'd0, WriteEn}, 32'd0);
        chk("stop_ack", {31'd0, ack}, 32'd0);
        chk("stop_readen", {31'd0, ReadEn}, 32'd0);
        if (use_reset) begin
          chk("rst_memadr", {24'd0, MemAdr}, 32'd0);
          chk("rst_datin", {24'd0, DatIn}, 32'd0);
          chk("rst_sec", {24'd0, sec_ct}, 32'd0);
          chk("rst_ded", {24'd0, ded_ct}, 32'd0);
        end
        break;
      end
      if (ack) begin
        rise = k;
        break;
      end
    end
    if (stop_at == 0) begin
      chk("ack_rise_edge", rise, 6 * NW + 1);
      chk("sec_ct", {24'd0, sec_ct}, exp_sec);
      chk("ded_ct", {24'd0, ded_ct}, exp_ded);
      for (int h = 0; h < 3; h++) begin
        @(posedge clk);
        @(negedge clk);
        chk("ack_hold", {31'd0, ack}, 32'd1);
      end
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ack_drop", {31'd0, ack}, 32'd0);
    end else begin
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic fill_random(input bit m);
    logic [15:0] c;
    int b1;
    int b2;
    int nf;
    for (int w = 0; w < NW; w++) begin
      if (!m) begin
        src_words[w] = 16'($urandom);
      end else begin
        c  = ref_encode(11'($urandom));
        nf = $urandom_range(0, 2);
        b1 = $urandom_range(0, 15);
        b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
        if (nf >= 1) c[b1] = ~c[b1];
        if (nf == 2) c[b2] = ~c[b2];
        src_words[w] = c;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    mode  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_memadr", {24'd0, MemAdr}, 32'd0);
    chk("reset_datin", {24'd0, DatIn}, 32'd0);
    chk("reset_readen", {31'd0, ReadEn}, 32'd0);
    chk("reset_writeen", {31'd0, WriteEn}, 32'd0);
    chk("reset_sec", {24'd0, sec_ct}, 32'd0);
    chk("reset_ded", {24'd0, ded_ct}, 32'd0);
    req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    fill_random(1'b0);
    src_words[0] = 16'h07FF;
    src_words[1] = 16'h0000;
    src_words[2] = 16'hF800;
    do_run(1'b0, 0, 1'b0);

    fill_random(1'b1);
    src_words[0] = 16'hFFDF;
    src_words[1] = 16'hFFD7;
    src_words[2] = 16'hFFFE;
    src_words[3] = 16'hFFFF;
    do_run(1'b1, 0, 1'b0);

    fill_random(1'b0);
    do_run(1'b0, 20, 1'b0);
    fill_random(1'b0);
    do_run(1'b0, 0, 1'b0);

    fill_random(1'b1);
    do_run(1'b1, 32, 1'b1);
    fill_random(1'b1);
    do_run(1'b1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
